// File: rtl/usb_tx_arb.sv
// usb_tx_arb: round-robin arbiter of two byte sources onto the MUACM tx stream, with idle flush
// Ports: clk/rst; s0_*/s1_* source byte streams (val/rdy); m_data/m_val/m_rdy toward MUACM;
// m_flush one-cycle flush request; grant current owner (00 none, 01 src0, 10 src1).
module usb_tx_arb #(
  parameter int MAX_BURST  = 64,
  parameter int FLUSH_IDLE = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_data,
  input  logic       s0_val,
  output logic       s0_rdy,
  input  logic [7:0] s1_data,
  input  logic       s1_val,
  output logic       s1_rdy,
  output logic [7:0] m_data,
  output logic       m_val,
  input  logic       m_rdy,
  output logic       m_flush,
  output logic [1:0] grant
);
  localparam int IW = $clog2(FLUSH_IDLE + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;
  state_t        r_state;
  logic [7:0]    r_burst;
  logic [IW-1:0] r_idle;
  logic          r_pending;
  logic          r_last;
  logic          w_free;
  logic          w_room;
  logic          w_acc0;
  logic          w_acc1;
  logic          w_acc;
  logic          w_xfer;
  logic          w_own_val;
  logic          w_rel;
  logic          w_flush;
  assign w_free    = !m_val || m_rdy;
  assign w_room    = r_burst < 8'(MAX_BURST);
  assign s0_rdy    = r_state == G0 && w_free && w_room;
  assign s1_rdy    = r_state == G1 && w_free && w_room;
  assign w_acc0    = s0_val && s0_rdy;
  assign w_acc1    = s1_val && s1_rdy;
  assign w_acc     = w_acc0 || w_acc1;
  assign w_xfer    = m_val && m_rdy;
  assign w_own_val = r_state == G0 ? s0_val : s1_val;
  // A source that drops val only loses the grant once the output stage could take a byte.
  assign w_rel     = (w_acc && r_burst == 8'(MAX_BURST - 1)) || (!w_own_val && w_free);
  assign w_flush   = r_pending && !m_val && r_idle == IW'(FLUSH_IDLE - 1);
  assign grant     = r_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_burst   <= '0;
      r_idle    <= '0;
      r_pending <= 1'b0;
      r_last    <= 1'b1;
      m_val     <= 1'b0;
      m_data    <= '0;
      m_flush   <= 1'b0;
    end else begin
      m_flush   <= w_flush;
      r_pending <= w_xfer || (r_pending && !w_flush);
      r_idle    <= (w_xfer || w_acc || w_flush) ? '0 :
                   r_idle == IW'(FLUSH_IDLE) ? r_idle : r_idle + 1'b1;
      if (w_acc) begin
        m_val   <= 1'b1;
        m_data  <= w_acc0 ? s0_data : s1_data;
        r_burst <= r_burst + 8'd1;
      end else if (w_xfer) begin
        m_val <= 1'b0;
      end
      case (r_state)
        IDLE: if (s0_val || s1_val) begin
          r_state <= (s0_val && (!s1_val || r_last)) ? G0 : G1;
          r_burst <= '0;
        end
        default: if (w_rel) begin
          r_state <= IDLE;
          r_last  <= r_state == G1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_usb_tx_arb.sv
// tb_usb_tx_arb: directed and randomized checks of usb_tx_arb against a transaction-level model
module tb_usb_tx_arb;
  localparam int MB = 4;
  localparam int FI = 16;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s0_data;
  logic       s0_val;
  logic       s0_rdy;
  logic [7:0] s1_data;
  logic       s1_val;
  logic       s1_rdy;
  logic [7:0] m_data;
  logic       m_val;
  logic       m_rdy;
  logic       m_flush;
  logic [1:0] grant;
  usb_tx_arb #(.MAX_BURST(MB), .FLUSH_IDLE(FI)) dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_val(s0_val), .s0_rdy(s0_rdy),
    .s1_data(s1_data), .s1_val(s1_val), .s1_rdy(s1_rdy),
    .m_data(m_data), .m_val(m_val), .m_rdy(m_rdy),
    .m_flush(m_flush), .grant(grant)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Source drivers: each source offers the head of its queue while enabled.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] got[$];
  bit en0 = 0, en1 = 0, nx_rst = 1, nx_rdy = 0, a0 = 0, a1 = 0;
  int nflush = 0;
  task automatic step();
    @(posedge clk);
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    rst     = nx_rst;
    m_rdy   = nx_rdy;
    s0_val  = en0 && q0.size() > 0;
    s0_data = q0.size() > 0 ? q0[0] : 8'h00;
    s1_val  = en1 && q1.size() > 0;
    s1_data = q1.size() > 0 ? q1[0] : 8'h00;
    @(negedge clk);
    a0 = s0_val && s0_rdy && !rst;
    a1 = s1_val && s1_rdy && !rst;
    if (m_val && m_rdy && !rst) got.push_back(m_data);
    if (m_flush) nflush++;
  endtask
  task automatic do_reset();
    en0 = 0; en1 = 0; nx_rst = 1;
    step();
    nx_rst = 0;
    q0.delete(); q1.delete(); got.delete(); nflush = 0;
  endtask
  // Reference model: outstanding-byte queue, grant rules, burst counting, flush timing by cycle stamps.
  logic [7:0] mq[$];
  int   cyc = 0, tlast = 0, burst = 0;
  bit   pend = 0, last1 = 1, p_rst = 1, p_fl = 0, p_s0v = 0, p_s1v = 0, p_free = 0, p_acc = 0;
  logic [1:0] p_grant = 2'b00;
  always @(negedge clk) begin
    bit free, ac0, ac1, xf, rel;
    logic [1:0] eg;
    if (p_rst) begin
      chk("rst_grant", 8'(grant), 8'h00);
      chk("rst_mval", 8'(m_val), 8'h00);
      chk("rst_mdata", m_data, 8'h00);
      chk("rst_flush", 8'(m_flush), 8'h00);
      chk("rst_rdy", {6'd0, s1_rdy, s0_rdy}, 8'h00);
    end else begin
      chk("flush", 8'(m_flush), 8'(p_fl));
      if (p_grant == 2'b00)
        eg = !(p_s0v || p_s1v) ? 2'b00 : (p_s0v && (!p_s1v || last1)) ? 2'b01 : 2'b10;
      else begin
        rel = (p_acc && burst == MB) || (!(p_grant == 2'b01 ? p_s0v : p_s1v) && p_free);
        eg = rel ? 2'b00 : p_grant;
      end
      chk("grant", 8'(grant), 8'(eg));
      if (grant != p_grant) burst = 0;
      free = !m_val || m_rdy;
      chk("rdy", {6'd0, s1_rdy, s0_rdy},
          {6'd0, grant == 2'b10 && free && burst < MB, grant == 2'b01 && free && burst < MB});
      chk("mval", 8'(m_val), 8'(mq.size() != 0));
      if (m_val === 1'b1 && mq.size() != 0) chk("mdata", m_data, mq[0]);
    end
    free = !m_val || m_rdy;
    ac0 = s0_val && s0_rdy;
    ac1 = s1_val && s1_rdy;
    xf = m_val && m_rdy;
    if (rst) begin
      mq.delete(); pend = 0; last1 = 1; p_fl = 0; burst = 0;
    end else begin
      p_fl = pend && !m_val && (cyc - tlast == FI);
      if (p_fl) pend = 0;
      if (xf) begin void'(mq.pop_front()); pend = 1; tlast = cyc; end
      if (ac0 || ac1) begin mq.push_back(ac0 ? s0_data : s1_data); tlast = cyc; burst++; end
      if (grant == 2'b00 && p_grant != 2'b00) last1 = p_grant == 2'b10;
    end
    p_rst = rst; p_grant = rst ? 2'b00 : grant; p_s0v = s0_val; p_s1v = s1_val;
    p_free = free; p_acc = ac0 || ac1;
    cyc++;
  end
  initial begin
    rst = 1; m_rdy = 0; s0_val = 0; s1_val = 0; s0_data = 0; s1_data = 0;
    // No traffic after reset: never flush.
    do_reset();
    nx_rdy = 1;
    repeat (3 * FI) step();
    chk("quiet_noflush", 8'(nflush), 8'd0);
    // Single source streaming 41..45.
    q0 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    en0 = 1;
    step();
    chk("single_g0_c0", 8'(grant), 8'h00);
    step();
    chk("single_g0_c1", 8'(grant), 8'h01);
    repeat (8) step();
    chk("single_grant_end", 8'(grant), 8'h00);
    chk("single_cnt", 8'(got.size()), 8'd5);
    for (int i = 0; i < 5; i++) chk("single_data", i < got.size() ? got[i] : 8'hxx, 8'(8'h41 + i));
    repeat (3 * FI) step();
    chk("single_one_flush", 8'(nflush), 8'd1);
    // Contention: both sources always valid.
    do_reset();
    nx_rdy = 1;
    for (int i = 0; i < 12; i++) begin q0.push_back(8'(8'h10 + i)); q1.push_back(8'(8'h80 + i)); end
    en0 = 1; en1 = 1;
    begin
      int acc_n = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        chk("cont_grant", 8'(grant), i % 5 == 0 ? 8'h00 : ((i / 5) % 2 ? 8'h02 : 8'h01));
        acc_n += int'(a0) + int'(a1);
      end
      chk("cont_accepts", 8'(acc_n), 8'd16);
    end
    // Backpressure mid-stream on source 1.
    do_reset();
    nx_rdy = 1;
    q1 = '{8'hA0, 8'hA1, 8'hA2};
    en1 = 1;
    repeat (3) step();
    nx_rdy = 0;
    repeat (10) begin
      step();
      chk("bp_hold_data", m_data, 8'hA1);
      chk("bp_hold_val", 8'(m_val), 8'h01);
      chk("bp_rdy", 8'(s1_rdy), 8'h00);
    end
    nx_rdy = 1;
    repeat (10) step();
    chk("bp_cnt", 8'(got.size()), 8'd3);
    for (int i = 0; i < 3; i++) chk("bp_data", i < got.size() ? got[i] : 8'hxx, 8'(8'hA0 + i));
    // Source 0 drops val while the stage is blocked.
    do_reset();
    nx_rdy = 0;
    q0 = '{8'hB0, 8'hB1};
    q1 = '{8'hC0};
    en0 = 1; en1 = 1;
    repeat (2) step();
    en0 = 0;
    repeat (5) begin
      step();
      chk("drop_keep_grant", 8'(grant), 8'h01);
    end
    nx_rdy = 1;
    step();
    chk("drop_release_cycle", 8'(grant), 8'h01);
    step();
    chk("drop_idle", 8'(grant), 8'h00);
    step();
    chk("drop_next_s1", 8'(grant), 8'h02);
    repeat (4) step();
    chk("drop_cnt", 8'(got.size()), 8'd2);
    chk("drop_d0", got.size() > 0 ? got[0] : 8'hxx, 8'hB0);
    chk("drop_d1", got.size() > 1 ? got[1] : 8'hxx, 8'hC0);
    // Reset while a byte is held in the output stage.
    do_reset();
    nx_rdy = 0;
    q0 = '{8'h55};
    en0 = 1;
    repeat (3) step();
    chk("mid_held", m_data, 8'h55);
    chk("mid_val", 8'(m_val), 8'h01);
    nx_rst = 1;
    step();
    nx_rst = 0; en0 = 0;
    step();
    chk("mid_mval", 8'(m_val), 8'h00);
    chk("mid_grant", 8'(grant), 8'h00);
    chk("mid_rdy", {6'd0, s1_rdy, s0_rdy}, 8'h00);
    chk("mid_flush", 8'(m_flush), 8'h00);
    nx_rdy = 1;
    nflush = 0;
    repeat (3 * FI) step();
    chk("mid_noflush", 8'(nflush), 8'd0);
    // Randomized traffic with quiet windows and one reset, checked by the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i % 200 >= 150) begin
        en0 = 0; en1 = 0; nx_rdy = 1;
      end else begin
        nx_rdy = $urandom_range(0, 3) != 0;
        en0 = $urandom_range(0, 4) != 0;
        en1 = $urandom_range(0, 2) != 0;
      end
      if (q0.size() < 2) q0.push_back(8'($urandom));
      if (q1.size() < 2) q1.push_back(8'($urandom));
      nx_rst = i == 420;
      step();
    end
    nx_rst = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/usb_tx_arb.md
Name: usb_tx_arb

Overview:
- Two-requester arbiter sharing the single MUACM transmit byte stream (tx_data/tx_val/tx_rdy) between byte sources, e.g. the CPU ACIA TX path and a hardware debug/log source.
- Per-source packet-level lock with bounded burst length and round-robin fairness.
- Registered output stage toward MUACM.
- Generates a one-cycle flush request after the output has been idle for a set time, so partial USB packets are pushed to the host.

Parameters:
- MAX_BURST, 64, max bytes accepted from one source per grant (1..255).
- FLUSH_IDLE, 1024, idle clock cycles after last transfer before m_flush pulses (2..65535).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- s0_data  input  8  source 0 byte
- s0_val  input  1  source 0 byte valid
- s0_rdy  output  1  source 0 byte accepted this cycle when s0_val&s0_rdy
- s1_data  input  8  source 1 byte
- s1_val  input  1  source 1 byte valid
- s1_rdy  output  1  source 1 accept
- m_data  output  8  byte to MUACM tx
- m_val  output  1  byte valid to MUACM
- m_rdy  input  1  MUACM ready; transfer when m_val&m_rdy
- m_flush  output  1  one-cycle flush request to MUACM
- grant  output  2  current owner: 00 none, 01 src0, 10 src1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values: state IDLE, grant=00, m_val=0, m_data=00, m_flush=0, s0_rdy=s1_rdy=0, burst_cnt=0, idle_cnt=0, pending=0, last=1 (so src0 wins the first tie).
- States:
  - IDLE, G0, G1. grant reflects state.
- IDLE transitions:
  - Only s0_val -> G0. Only s1_val -> G1.
  - Both valid -> the source other than last.
  - Neither valid -> stay.
  - burst_cnt cleared on every entry to G0/G1.
- Stage-free condition: free = !m_val | m_rdy.
- Ready signals:
  - sN_rdy = (state==GN) & free & (burst_cnt < MAX_BURST). Combinational.
  - Never asserted in IDLE, so a grant costs one bubble cycle.
- Accept (sN_val & sN_rdy): m_data<=sN_data, m_val<=1, burst_cnt+1. Latency source->m_val is 1 cycle.
- Output drain: m_val&m_rdy with no new accept -> m_val<=0. Simultaneous drain and accept keeps m_val=1 with the new data, giving back-to-back throughput of 1 byte/cycle.
- Release GN -> IDLE, setting last<=N, when either:
  - (a) the accept makes burst_cnt==MAX_BURST, or
  - (b) sN_val=0 in a cycle where free=1.
- A source dropping val while the stage is blocked (free=0) keeps the grant.
- m_data/m_val hold stable while m_val=1 & m_rdy=0. No data loss and no duplication.
- Flush logic:
  - pending<=1 on any transfer (m_val&m_rdy).
  - idle_cnt resets to 0 on any transfer or any accept. Otherwise it increments, saturating at FLUSH_IDLE.
  - When pending & !m_val & idle_cnt==FLUSH_IDLE-1: m_flush=1 for exactly one cycle, pending<=0, idle_cnt<=0.
  - No flush occurs without a prior transfer. No repeated flushes while idle.
- Reset mid-operation: any byte held in the output stage is dropped, m_val deasserts the cycle after rst, and the grant is lost.
- Counter widths:
  - burst_cnt: 8 bits.
  - idle_cnt: clog2(FLUSH_IDLE+1) bits.

Test Plan:
- Single source: s0 streams 5 bytes 41..45 with m_rdy=1 and s1 idle.
  - grant=01 one cycle after s0_val.
  - m_data sequence 41,42,43,44,45 on consecutive cycles.
  - Release to IDLE after s0_val drops.
  - m_flush pulses exactly once, FLUSH_IDLE cycles after the last transfer.
- Contention: s0 and s1 both continuously valid, MAX_BURST=4, reset state.
  - Grants alternate 01,10,01,...
  - Each grant accepts exactly 4 bytes, with one bubble cycle between grants.
  - The first grant goes to src0.
- Backpressure: s1 sends A0,A1,A2 and m_rdy=0 for 10 cycles mid-stream.
  - m_data holds A1 stable and s1_rdy=0 throughout.
  - After m_rdy=1, A1 then A2 appear. No loss or duplication.
- Valid drop while blocked: s0_val falls while m_val=1 & m_rdy=0.
  - grant stays 01 until m_rdy=1.
  - Then IDLE, and a waiting s1 is granted next.
- Reset mid-burst: assert rst with m_val=1 holding 55.
  - Next cycle: m_val=0, grant=00, all rdy=0, m_flush=0.
  - No flush afterwards without a new transfer.
- Flush suppression: no traffic for 3*FLUSH_IDLE cycles after reset -> m_flush never asserts. Then 1 byte sent -> exactly one pulse.
